// File: rtl/seq_shift_add_mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
// Optional rounded output is enabled with the SEQ_SHIFT_ADD_MULT_ROUND_EN macro.
package seq_shift_add_mult_pkg;

    // Controller states: IDLE waits for start, RUN steps one partial product
    // per clock, DONE holds the one-cycle completion pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter width: must hold values 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Half of one LSB of the fixed-point result: 2^(frac-1), added before
    // the right shift to round half up.
    function automatic logic [63:0] round_half(input int frac);
        return 64'd1 << (frac - 1);
    endfunction

endpackage

// File: rtl/seq_shift_add_mult_ripple_adder.sv
// N-bit combinational ripple-carry adder built from one half-adder cell at
// bit 0 followed by a chain of full-adder cells.
module ripple_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] sum,
    output logic         cout
);

    // carry[i] is the carry into bit i; there is no carry into bit 0.
    logic [N:1] carry;

    // Bit 0: half-adder cell.
    assign sum[0]   = x[0] ^ y[0];
    assign carry[1] = x[0] & y[0];

    // Bits 1..N-1: full-adder cells rippling the carry upward.
    for (genvar i = 1; i < N; i++) begin : g_fa
        assign sum[i]     = x[i] ^ y[i] ^ carry[i];
        assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end

    assign cout = carry[N];

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier, one partial product per clock.
// Fixed latency of WIDTH edges from the accepted start to the done pulse.
// Define SEQ_SHIFT_ADD_MULT_ROUND_EN to add product_rnd, the product rounded
// half up from Q(WIDTH-FRAC).FRAC squared back to WIDTH bits, saturating.
module seq_shift_add_mult
    import seq_shift_add_mult_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
`ifdef SEQ_SHIFT_ADD_MULT_ROUND_EN
    ,
    output logic [WIDTH-1:0]   product_rnd
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    // Handshake: start is only looked at in IDLE or DONE; an accepted start
    // raises busy from that edge until the completion edge, where done pulses
    // for exactly one cycle and product updates. start during RUN is ignored.

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_hi;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum_lo;
    logic             sum_co;
    logic [WIDTH-1:0] acc_hi_nxt;
    logic [WIDTH-1:0] mplier_nxt;

    // One partial product: add the multiplicand when the current multiplier
    // LSB is set, then shift {carry, sum, mplier} right by one.
    assign addend = mplier[0] ? mcand : '0;

    ripple_adder #(.N(WIDTH)) u_add (
        .x    (acc_hi),
        .y    (addend),
        .sum  (sum_lo),
        .cout (sum_co)
    );

    assign acc_hi_nxt = {sum_co, sum_lo[WIDTH-1:1]};
    assign mplier_nxt = {sum_lo[0], mplier[WIDTH-1:1]};

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST_STEP) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture and per-step accumulate/shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc_hi <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= a;
            mplier <= b;
            acc_hi <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc_hi <= acc_hi_nxt;
            mplier <= mplier_nxt;
            cnt    <= cnt + 1'b1;
        end
    end

    // Result register: loads only on the completion edge.
    always_ff @(posedge clk) begin
        if (rst)       product <= '0;
        else if (last) product <= {acc_hi_nxt, mplier_nxt};
    end

`ifdef SEQ_SHIFT_ADD_MULT_ROUND_EN
    localparam logic [2*WIDTH:0] HALF = (2*WIDTH+1)'(round_half(FRAC));

    logic [2*WIDTH:0]   rnd_sum;
    logic [2*WIDTH:0]   rnd_shift;
    logic [WIDTH-1:0]   rnd_val;

    // Round half up from the final product, saturating if it exceeds WIDTH bits.
    always_comb begin
        rnd_sum   = {1'b0, acc_hi_nxt, mplier_nxt} + HALF;
        rnd_shift = rnd_sum >> FRAC;
        rnd_val   = (|rnd_shift[2*WIDTH:WIDTH]) ? '1 : rnd_shift[WIDTH-1:0];
    end

    // Rounded result register, updated alongside product.
    always_ff @(posedge clk) begin
        if (rst)       product_rnd <= '0;
        else if (last) product_rnd <= rnd_val;
    end
`endif

endmodule
